led_fade_driver: RTL



---
 rtl/led_fade_pkg.sv | 20 ++
 rtl/led_fade_channel.sv | 81 ++++++++
 rtl/led_fade_driver.sv | 96 +++++++++
 3 files changed

// File: rtl/led_fade_pkg.sv
// Shared definitions for the LED fade driver: channel state encoding and duty sizing.
package led_fade_pkg;

  localparam int DUTY_W   = 8;
  localparam int DUTY_MAX = 255;

  // Channel state; the two ramp states are the "busy" ones.
  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } fade_state_e;

  // True while a channel is moving its duty towards a target.
  function automatic logic is_ramping(input fade_state_e s);
    return (s == RAMP_UP) || (s == RAMP_DOWN);
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: on/off request FSM, 8-bit duty ramp and PWM compare.
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              fade_en,
  input  logic              ramp_tick,
  input  logic [DUTY_W-1:0] pwm_cnt,
  output logic              lit,
  output logic              busy
);

  fade_state_e       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W:0]   sum9;

  // Headroom bit makes the saturation test exact for any STEP up to 255.
  assign sum9 = {1'b0, duty_q} + (DUTY_W + 1)'(STEP);

  // Next state and duty: hard override when fading is off, otherwise direction then step.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    if (!fade_en) begin
      if (req) begin
        state_d = ON;
        duty_d  = DUTY_W'(DUTY_MAX);
      end else begin
        state_d = OFF;
        duty_d  = '0;
      end
    end else begin
      case (state_q)
        OFF:       if (req)  state_d = RAMP_UP;
        ON:        if (!req) state_d = RAMP_DOWN;
        RAMP_UP:   if (!req) state_d = RAMP_DOWN;
        RAMP_DOWN: if (req)  state_d = RAMP_UP;
        default:   state_d = OFF;
      endcase
      // Only a channel already ramping takes a step; a reversal on the tick
      // edge steps in the new direction because state_d is consulted here.
      if (ramp_tick && is_ramping(state_q)) begin
        if (state_d == RAMP_UP) begin
          if (sum9 >= (DUTY_W + 1)'(DUTY_MAX)) begin
            duty_d  = DUTY_W'(DUTY_MAX);
            state_d = ON;
          end else begin
            duty_d = sum9[DUTY_W-1:0];
          end
        end else if (state_d == RAMP_DOWN) begin
          if ({1'b0, duty_q} <= (DUTY_W + 1)'(STEP)) begin
            duty_d  = '0;
            state_d = OFF;
          end else begin
            duty_d = duty_q - DUTY_W'(STEP);
          end
        end
      end
    end
  end

  // State and duty registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OFF;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
    end
  end

  // Full duty is forced lit so the pwm_cnt==255 slot does not blink dark.
  assign lit  = (duty_q == DUTY_W'(DUTY_MAX)) ? 1'b1 : (pwm_cnt < duty_q);
  assign busy = is_ramping(state_q);

endmodule

// File: rtl/led_fade_driver.sv
// LED fade driver: shared PWM/ramp timebase, request capture, per-channel faders, pin polarity.
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int NUM_LEDS       = 4,
  parameter int PWM_DIV        = 8,
  parameter int RAMP_DIV       = 4,
  parameter int STEP           = 8,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] pio_in,
  input  logic                fade_en,
  output logic [NUM_LEDS-1:0] led,
  output logic [NUM_LEDS-1:0] busy
);

  localparam int PRE_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [DUTY_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
  logic                pwm_tick, period_end, ramp_tick;
  logic [NUM_LEDS-1:0] req_q;
  logic [NUM_LEDS-1:0] lit;
  logic [NUM_LEDS-1:0] led_q;

  assign pwm_tick   = (pre_cnt_q == PRE_W'(PWM_DIV - 1));
  assign period_end = pwm_tick && (pwm_cnt_q == DUTY_W'(DUTY_MAX));
  assign ramp_tick  = period_end && (ramp_cnt_q == RAMP_W'(RAMP_DIV - 1));

  // Timebase next-state: prescaler, 8-bit PWM counter, ramp period counter.
  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    pwm_cnt_d  = pwm_cnt_q;
    ramp_cnt_d = ramp_cnt_q;
    pre_cnt_d  = pwm_tick ? '0 : pre_cnt_q + 1'b1;
    if (pwm_tick) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end
    if (period_end) begin
      ramp_cnt_d = ramp_tick ? '0 : ramp_cnt_q + 1'b1;
    end
  end

  // Timebase registers shared by all channels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      ramp_cnt_q <= '0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      ramp_cnt_q <= ramp_cnt_d;
    end
  end

  // Request capture; pio_in is already in this clock domain so one flop suffices.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= '0;
    end else begin
      req_q <= pio_in;
    end
  end

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
    led_fade_channel #(
      .STEP(STEP)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .req      (req_q[gi]),
      .fade_en  (fade_en),
      .ramp_tick(ramp_tick),
      .pwm_cnt  (pwm_cnt_q),
      .lit      (lit[gi]),
      .busy     (busy[gi])
    );
  end

  // Registered pin drive with board polarity applied; reset leaves every LED dark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= {NUM_LEDS{LED_ACTIVE_LOW}};
    end else begin
      led_q <= lit ^ {NUM_LEDS{LED_ACTIVE_LOW}};
    end
  end

  assign led = led_q;

endmodule
